// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate-extension controller: opcode decode, 32-bit immediate
// generation and a registered two-entry skid buffer toward the execute stage.
module imm_ext_ctrl #(
    parameter int CNT_W    = 16,
    parameter bit BR_SHIFT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_mode,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] MODE_NONE   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_ZERO   = 3'd2;
    localparam logic [2:0] MODE_LUI    = 3'd3;
    localparam logic [2:0] MODE_BRANCH = 3'd4;
    localparam logic [2:0] MODE_JUMP   = 3'd5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [31:0]      main_imm_q;
    logic [2:0]       main_mode_q;
    logic             main_ill_q;
    logic [31:0]      skid_imm_q;
    logic [2:0]       skid_mode_q;
    logic             skid_ill_q;
    logic [CNT_W-1:0] cnt_q;

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic [31:0] sext;
    logic [31:0] dec_imm_d;
    logic [2:0]  dec_mode_d;
    logic        dec_ill_d;
    logic        acc;
    logic        drn;

    assign opcode = instr[31:26];
    assign imm16  = instr[15:0];
    assign sext   = {{16{imm16[15]}}, imm16};

    always_comb begin
        dec_imm_d  = 32'h0;
        dec_mode_d = MODE_NONE;
        dec_ill_d  = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_mode_d = MODE_NONE;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b100011, 6'b101011: begin
                dec_mode_d = MODE_SIGN;
                dec_imm_d  = sext;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                dec_mode_d = MODE_ZERO;
                dec_imm_d  = {16'h0, imm16};
            end
            6'b001111: begin
                dec_mode_d = MODE_LUI;
                dec_imm_d  = {imm16, 16'h0};
            end
            6'b000100, 6'b000101: begin
                dec_mode_d = MODE_BRANCH;
                dec_imm_d  = BR_SHIFT ? {sext[29:0], 2'b00} : sext;
            end
            6'b000010, 6'b000011: begin
                dec_mode_d = MODE_JUMP;
                dec_imm_d  = {4'h0, instr[25:0], 2'b00};
            end
            default: begin
                dec_ill_d = 1'b1;
            end
        endcase
    end

    assign acc = in_valid & in_ready_q;
    assign drn = out_valid_q & out_ready;

    // The counter sees every accepted word, so an illegal opcode dropped by a
    // simultaneous flush is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (acc && dec_ill_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // in_ready is just "skid empty", registered alongside the state so it
    // never combinationally depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_imm_q  <= 32'h0;
            main_mode_q <= MODE_NONE;
            main_ill_q  <= 1'b0;
            skid_imm_q  <= 32'h0;
            skid_mode_q <= MODE_NONE;
            skid_ill_q  <= 1'b0;
        end else if (flush) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_imm_q  <= dec_imm_d;
                        main_mode_q <= dec_mode_d;
                        main_ill_q  <= dec_ill_d;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !drn) begin
                        skid_imm_q  <= dec_imm_d;
                        skid_mode_q <= dec_mode_d;
                        skid_ill_q  <= dec_ill_d;
                        state_q     <= TWO;
                        in_ready_q  <= 1'b0;
                    end else if (acc && drn) begin
                        main_imm_q  <= dec_imm_d;
                        main_mode_q <= dec_mode_d;
                        main_ill_q  <= dec_ill_d;
                    end else if (drn) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (drn) begin
                        main_imm_q  <= skid_imm_q;
                        main_mode_q <= skid_mode_q;
                        main_ill_q  <= skid_ill_q;
                        state_q     <= ONE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = main_imm_q;
    assign out_mode    = main_mode_q;
    assign out_illegal = main_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed self-checking bench for imm_ext_ctrl; a second instance with a
// 2-bit counter shares all inputs so counter saturation can be observed.
module tb_imm_ext_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_mode;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_imm2;
    logic [2:0]  out_mode2;
    logic        out_illegal2;
    logic [1:0]  illegal_cnt2;

    int checks = 0;
    int errors = 0;

    imm_ext_ctrl #(.CNT_W(16), .BR_SHIFT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_mode(out_mode), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_ext_ctrl #(.CNT_W(2), .BR_SHIFT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .instr(instr), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_imm(out_imm2), .out_mode(out_mode2), .out_illegal(out_illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [31:0] w,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        instr     = w;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pushWord [6];
    logic [31:0] expImm   [6];
    logic [2:0]  expMode  [6];

    initial begin
        pushWord[0] = 32'h2008FFFF; expImm[0] = 32'hFFFFFFFF; expMode[0] = 3'd1;
        pushWord[1] = 32'h3408FFFF; expImm[1] = 32'h0000FFFF; expMode[1] = 3'd2;
        pushWord[2] = 32'h3C081234; expImm[2] = 32'h12340000; expMode[2] = 3'd3;
        pushWord[3] = 32'h1000FFFE; expImm[3] = 32'hFFFFFFF8; expMode[3] = 3'd4;
        pushWord[4] = 32'h08000040; expImm[4] = 32'h00000100; expMode[4] = 3'd5;
        pushWord[5] = 32'h0000FF20; expImm[5] = 32'h00000000; expMode[5] = 3'd0;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        stepClk();
        stepClk();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_imm", out_imm, 32'h0);
        checkOutput("rst_out_mode", 32'(out_mode), 32'd0);
        checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
        checkOutput("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
        rst = 1'b0;
        stepClk();

        // Single pushes, one result per accept, one cycle later.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, pushWord[i], 1'b1, 1'b0);
            checkOutput($sformatf("single%0d_in_ready", i), 32'(in_ready), 32'd1);
            stepClk();
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            checkOutput($sformatf("single%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("single%0d_imm", i), out_imm, expImm[i]);
            checkOutput($sformatf("single%0d_mode", i), 32'(out_mode), 32'(expMode[i]));
            checkOutput($sformatf("single%0d_illegal", i), 32'(out_illegal), 32'd0);
            stepClk();
            checkOutput($sformatf("single%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Back-pressure fills the skid and holds off a third word.
        applyStimulus(1'b1, 32'h20080001, 1'b0, 1'b0);
        stepClk();
        applyStimulus(1'b1, 32'h20080002, 1'b0, 1'b0);
        checkOutput("bp_in_ready_one", 32'(in_ready), 32'd1);
        stepClk();
        checkOutput("bp_in_ready_two", 32'(in_ready), 32'd0);
        checkOutput("bp_imm_hold1", out_imm, 32'h00000001);
        applyStimulus(1'b1, 32'h20080003, 1'b0, 1'b0);
        stepClk();
        checkOutput("bp_in_ready_held", 32'(in_ready), 32'd0);
        checkOutput("bp_imm_hold2", out_imm, 32'h00000001);
        checkOutput("bp_mode_hold", 32'(out_mode), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
        stepClk();
        checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_second_imm", out_imm, 32'h00000002);
        checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
        stepClk();
        checkOutput("bp_empty", 32'(out_valid), 32'd0);
        checkOutput("bp_in_ready_end", 32'(in_ready), 32'd1);

        // Streaming: eight back-to-back words, one output per cycle in order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, {6'b001000, 10'h0, 16'(i + 16'h0100)}, 1'b1, 1'b0);
            checkOutput($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
            stepClk();
            checkOutput($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stream%0d_imm", i), out_imm, 32'(i + 32'h0100));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        stepClk();
        checkOutput("stream_end_valid", 32'(out_valid), 32'd0);

        // Flush in TWO with a third word offered and downstream ready.
        applyStimulus(1'b1, 32'h2008AAAA, 1'b0, 1'b0);
        stepClk();
        applyStimulus(1'b1, 32'h2008BBBB, 1'b0, 1'b0);
        stepClk();
        checkOutput("flush_pre_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 32'h2008CCCC, 1'b1, 1'b1);
        stepClk();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        stepClk();
        checkOutput("flush_stays_empty", 32'(out_valid), 32'd0);

        // Flush together with an accept in EMPTY drops the incoming word.
        applyStimulus(1'b1, 32'h2008DDDD, 1'b1, 1'b1);
        stepClk();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_acc_dropped", 32'(out_valid), 32'd0);

        // Illegal opcodes: flag, zero immediate, counter and saturation.
        applyStimulus(1'b1, 32'h7C000000, 1'b1, 1'b0);
        stepClk();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("ill_valid", 32'(out_valid), 32'd1);
        checkOutput("ill_flag", 32'(out_illegal), 32'd1);
        checkOutput("ill_imm", out_imm, 32'h0);
        checkOutput("ill_mode", 32'(out_mode), 32'd0);
        checkOutput("ill_cnt1", 32'(illegal_cnt), 32'd1);
        checkOutput("ill_cnt1_w2", 32'(illegal_cnt2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h7C00FFFF, 1'b1, 1'b0);
            stepClk();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        stepClk();
        checkOutput("ill_cnt5", 32'(illegal_cnt), 32'd5);
        checkOutput("ill_cnt_sat_w2", 32'(illegal_cnt2), 32'd3);

        // Asynchronous reset while TWO, asserted between clock edges.
        applyStimulus(1'b1, 32'h20081111, 1'b0, 1'b0);
        stepClk();
        applyStimulus(1'b1, 32'h20082222, 1'b0, 1'b0);
        stepClk();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("arst_pre_in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("arst_cnt", 32'(illegal_cnt), 32'd0);
        checkOutput("arst_imm", out_imm, 32'h0);
        #1 rst = 1'b0;
        stepClk();
        checkOutput("arst_after_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
